fifo_param: RTL and testbench

// Parametrised synchronous valid/ready FIFO, next generation of the team's FIFO block.

---
 rtl/fifo_param.sv | 119 +++++++++++
 tb/tb_fifo_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised valid/ready FIFO (first-word-fall-through) for any DEPTH >= 2.
// Provides an occupancy count, almost-empty/almost-full flags, a synchronous flush and a high-water mark.
module fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 10,
  parameter int AE_THRESH = 2,
  parameter int AF_THRESH = 8,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_val,
  output logic             data_in_rdy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_val,
  input  logic             data_out_rdy,
  input  logic             flush,
  input  logic             clear_hwm,
  output logic             empty,
  output logic             almost_empty,
  output logic             full,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    hwm
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_param: DEPTH must be >= 2");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("fifo_param: AE_THRESH must be < DEPTH");
  end
  if (AF_THRESH == 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_THRESH must be in 1..DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] hwm_q, hwm_d;
  logic          push, pop;

  // Every flag decodes only from the registered count, so no input reaches an output combinationally.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign data_in_rdy  = !full;
  assign data_out_val = !empty;
  assign data_out     = empty ? '0 : mem[rd_ptr_q];
  assign count        = count_q;
  assign hwm          = hwm_q;

  assign push = data_in_val & data_in_rdy;
  assign pop  = data_out_val & data_out_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Tracking the post-update count means a flush leaves the mark untouched, while clear always wins.
  always_comb begin
    hwm_d = hwm_q;
    if (clear_hwm) begin
      hwm_d = '0;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed and randomised checks of fifo_param with default parameters (WIDTH=8, DEPTH=10).
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             data_in_val;
  logic             data_in_rdy;
  logic [WIDTH-1:0] data_out;
  logic             data_out_val;
  logic             data_out_rdy;
  logic             flush;
  logic             clear_hwm;
  logic             empty, almost_empty, full, almost_full;
  logic [CW-1:0]    count, hwm;

  int total = 0;
  int bad   = 0;

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AE_THRESH(2), .AF_THRESH(8)) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .data_in_val(data_in_val), .data_in_rdy(data_in_rdy),
    .data_out(data_out), .data_out_val(data_out_val), .data_out_rdy(data_out_rdy),
    .flush(flush), .clear_hwm(clear_hwm),
    .empty(empty), .almost_empty(almost_empty), .full(full), .almost_full(almost_full),
    .count(count), .hwm(hwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and return 1ns after the capturing edge.
  task automatic cyc(input logic val, input logic [7:0] din, input logic rdy);
    data_in      = din;
    data_in_val  = val;
    data_out_rdy = rdy;
    @(posedge clk);
    #1;
    data_in_val  = 1'b0;
    data_out_rdy = 1'b0;
    flush        = 1'b0;
    clear_hwm    = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_aempty"}, almost_empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_rdy"}, data_in_rdy, 1);
    chk({tag, "_val"}, data_out_val, 0);
    chk({tag, "_dout"}, data_out, 0);
  endtask

  logic [7:0] q[$];
  int         hwm_m;
  bit         val_r, rdy_r, do_push, do_pop;
  logic [7:0] din_r;

  initial begin
    reset = 1'b0; data_in = '0; data_in_val = 0; data_out_rdy = 0; flush = 0; clear_hwm = 0;

    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    chk_idle("t1");
    chk("t1_hwm", hwm, 0);
    reset = 1'b1;
    cyc(0, 8'h00, 0);

    // T2 fill
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 8'(i), 0);
      chk($sformatf("t2_count%0d", i), count, i);
      chk($sformatf("t2_afull%0d", i), almost_full, (i >= 8));
      chk($sformatf("t2_full%0d", i), full, (i == 10));
      chk($sformatf("t2_aempty%0d", i), almost_empty, (i <= 2));
      chk($sformatf("t2_head%0d", i), data_out, 8'h01);
    end
    chk("t2_rdy", data_in_rdy, 0);
    chk("t2_hwm", hwm, 10);
    cyc(1, 8'hFF, 0);
    chk("t2_ovf_count", count, 10);
    chk("t2_ovf_head", data_out, 8'h01);

    // T3 drain then streaming with wrap
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("t3_drain%0d", i), data_out, i);
      cyc(0, 8'h00, 1);
    end
    chk("t3_empty", empty, 1);
    chk("t3_count", count, 0);
    cyc(1, 8'h20, 1);
    chk("t3_lat_val", data_out_val, 1);
    chk("t3_lat_dout", data_out, 8'h20);
    for (int k = 1; k < 25; k++) begin
      chk($sformatf("t3_stream%0d", k), data_out, 8'h20 + k - 1);
      cyc(1, 8'(8'h20 + k), 1);
      chk($sformatf("t3_scount%0d", k), count, 1);
    end
    chk("t3_last", data_out, 8'h38);
    cyc(0, 8'h00, 1);
    chk("t3_end_empty", empty, 1);

    // T4 simultaneous push/pop at count 5
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h31 + i), 0);
    chk("t4_count5", count, 5);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t4_head%0d", k), data_out, (k < 5) ? (8'h31 + k) : (8'h40 + k - 5));
      cyc(1, 8'(8'h40 + k), 1);
      chk($sformatf("t4_count%0d", k), count, 5);
    end
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0);
    chk("t4_full", full, 1);
    chk("t4_head_full", data_out, 8'h4F);
    cyc(1, 8'hEE, 1);
    chk("t4_poponly_count", count, 9);
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("t4_drain%0d", j), data_out, (j < 4) ? (8'h50 + j) : (8'h60 + j - 4));
      cyc(0, 8'h00, 1);
    end
    chk_idle("t4_drained");
    cyc(1, 8'h77, 1);
    chk("t4_pushonly_count", count, 1);
    chk("t4_pushonly_dout", data_out, 8'h77);
    cyc(0, 8'h00, 1);
    chk("t4_final_count", count, 0);

    // T5 flush and high-water mark
    clear_hwm = 1'b1;
    cyc(0, 8'h00, 0);
    chk("t5_hwm_clr0", hwm, 0);
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'h80 + i), 0);
    chk("t5_count7", count, 7);
    chk("t5_hwm7", hwm, 7);
    flush = 1'b1;
    cyc(1, 8'hAA, 0);
    chk_idle("t5_flush");
    chk("t5_hwm_after_flush", hwm, 7);
    clear_hwm = 1'b1;
    cyc(0, 8'h00, 0);
    chk("t5_hwm_clr", hwm, 0);
    clear_hwm = 1'b1;
    cyc(1, 8'h5A, 0);
    chk("t5_clr_push_hwm", hwm, 0);
    chk("t5_clr_push_count", count, 1);
    chk("t5_clr_push_dout", data_out, 8'h5A);
    flush = 1'b1; clear_hwm = 1'b1;
    cyc(0, 8'h00, 1);
    chk("t5_both_count", count, 0);
    chk("t5_both_hwm", hwm, 0);

    // T6 random traffic against a queue scoreboard, with a reset pulse mid-run
    q.delete();
    hwm_m = 0;
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) begin
        data_in_val = 1'b1; data_out_rdy = 1'b0;
        reset = 1'b0;
        #1;
        chk_idle("t6_async_rst");
        chk("t6_async_rst_hwm", hwm, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_idle("t6_rst_held");
        data_in_val = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        hwm_m = 0;
      end
      chk("t6_count", count, q.size());
      chk("t6_val", data_out_val, (q.size() != 0));
      chk("t6_rdy", data_in_rdy, (q.size() != DEPTH));
      chk("t6_dout", data_out, (q.size() != 0) ? q[0] : 8'h00);
      chk("t6_hwm", hwm, hwm_m);
      val_r = ($urandom_range(0, 99) < ((c % 200) < 100 ? 75 : 35));
      rdy_r = ($urandom_range(0, 99) < ((c % 200) < 100 ? 35 : 75));
      din_r = 8'($urandom_range(0, 255));
      do_push = val_r && (q.size() < DEPTH);
      do_pop  = rdy_r && (q.size() > 0);
      cyc(val_r, din_r, rdy_r);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(din_r);
      if (q.size() > hwm_m) hwm_m = q.size();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
